// File: rtl/reloj_pkg.sv
// Shared definitions for the tick scheduler: config FSM encodings and default widths.
package reloj_pkg;

    localparam int unsigned PW_DEF = 16;
    localparam int unsigned CW_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/tick_scheduler_if.sv
// Configuration write port of the tick scheduler (req/ack handshake).
interface tick_scheduler_if
    import reloj_pkg::*;
#(
    parameter int unsigned CW = CW_DEF,
    parameter int unsigned PW = PW_DEF
);

    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [PW-1:0] cfg_period;
    logic          cfg_ack;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_period,
        input  cfg_ack
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_period,
        output cfg_ack
    );

endinterface

// File: rtl/tick_channel.sv
// One divider channel: period register, base-tick counter, tick strobe and optional square wave.
// Square-wave flop is built only when RELOJ_SQW_EN is defined.
module tick_channel
    import reloj_pkg::*;
#(
    parameter int unsigned PW = PW_DEF
) (
    input  logic          clkin,
    input  logic          rstn,
    input  logic          i_b,
    input  logic          i_en,
    input  logic          i_wr,
    input  logic [PW-1:0] i_period,
    output logic          o_tick,
    output logic          o_clk_div
);

    logic [PW-1:0] r_period;
    logic [PW-1:0] r_cnt;
    logic          r_tick;
    logic          w_wrap;
    logic          w_fire;

    assign w_wrap = (r_cnt == r_period - PW'(1));
    assign w_fire = i_b && i_en && (r_period != '0) && w_wrap;

    // A write in the same cycle as a wrap wins: counter restarts, no tick.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_wr) begin
                r_period <= i_period;
                r_cnt    <= '0;
            end else if (r_period == '0) begin
                r_cnt <= '0;
            end else if (i_b && i_en) begin
                if (w_wrap) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + PW'(1);
                end
            end
        end
    end

    assign o_tick = r_tick;

`ifdef RELOJ_SQW_EN
    logic r_sqw;

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_sqw <= 1'b0;
        end else if (i_wr) begin
            r_sqw <= 1'b0;
        end else if (w_fire) begin
            r_sqw <= ~r_sqw;
        end
    end

    assign o_clk_div = r_sqw;
`else
    logic w_unused_fire;
    assign w_unused_fire = w_fire;
    assign o_clk_div     = 1'b0;
`endif

endmodule

// File: rtl/tick_scheduler.sv
// Shared timebase: prescaler producing a base tick plus NCH programmable divider channels.
// Optional square-wave outputs are enabled by defining RELOJ_SQW_EN.
module tick_scheduler
    import reloj_pkg::*;
#(
    parameter int unsigned PRE_CNT = 50000,
    parameter int unsigned NCH     = 4,
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned PW      = PW_DEF
) (
    input  logic             clkin,
    input  logic             rstn,
    tick_scheduler_if.slave  cfg,
    input  logic [NCH-1:0]   ch_en,
    output logic             tick_base,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   clk_div
);

    localparam int unsigned PRE_W = $clog2(PRE_CNT);

    logic [PRE_W-1:0] r_pre_cnt;
    logic             r_tick_base;
    logic             w_b;
    cfg_state_e       r_state;
    logic             r_ack;
    logic             w_wr;

    assign w_b = (r_pre_cnt == PRE_W'(PRE_CNT - 1));

    // Prescaler and registered base-tick strobe.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_pre_cnt   <= '0;
            r_tick_base <= 1'b0;
        end else begin
            r_pre_cnt   <= w_b ? '0 : r_pre_cnt + PRE_W'(1);
            r_tick_base <= w_b;
        end
    end

    assign tick_base = r_tick_base;

    // Config handshake: one write and one ack per cfg_we assertion, however long it is held.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg.cfg_we) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end
                end
                ACK:     r_state <= WAIT;
                WAIT:    if (!cfg.cfg_we) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_wr        = (r_state == IDLE) && cfg.cfg_we;
    assign cfg.cfg_ack = r_ack;

    // Out-of-range channel selects match no channel but are still acknowledged.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        tick_channel #(
            .PW (PW)
        ) u_ch (
            .clkin     (clkin),
            .rstn      (rstn),
            .i_b       (w_b),
            .i_en      (ch_en[gi]),
            .i_wr      (w_wr && (cfg.cfg_ch == CW'(gi))),
            .i_period  (cfg.cfg_period),
            .o_tick    (tick[gi]),
            .o_clk_div (clk_div[gi])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler (PRE_CNT=4, NCH=4); clk_div expectations follow RELOJ_SQW_EN.
module tb_tick_scheduler;

    localparam int PRE = 4;
    localparam int NCH = 4;

    logic       clkin = 1'b0;
    logic       rstn  = 1'b0;
    logic [3:0] ch_en = 4'b0;
    logic       tick_base;
    logic [3:0] tick;
    logic [3:0] clk_div;

    int errors = 0;
    int checks = 0;

    tick_scheduler_if #(.CW(2), .PW(16)) cfg_bus ();

    tick_scheduler #(
        .PRE_CNT (PRE),
        .NCH     (NCH),
        .CW      (2),
        .PW      (16)
    ) dut (
        .clkin     (clkin),
        .rstn      (rstn),
        .cfg       (cfg_bus),
        .ch_en     (ch_en),
        .tick_base (tick_base),
        .tick      (tick),
        .clk_div   (clk_div)
    );

    always #5 clkin = ~clkin;

    // Reference model: base ticks from edge count since reset; each channel counts
    // active base ticks since its last write, ticks on multiples of its period and
    // its square wave is the parity of the number of ticks since that write.
    int         m_n;
    int         m_phase;
    int         m_per [NCH];
    int         m_k   [NCH];
    bit         m_b;
    bit         m_wr;
    logic [9:0] m_e;
    logic [9:0] exp_q [$];

    always @(posedge clkin) begin
        m_e = '0;
        if (!rstn) begin
            m_n     = 0;
            m_phase = 0;
            for (int i = 0; i < NCH; i++) begin
                m_per[i] = 0;
                m_k[i]   = 0;
            end
        end else begin
            m_n++;
            m_b  = (m_n % PRE == 0);
            m_wr = cfg_bus.cfg_we && (m_phase == 0);
            case (m_phase)
                0:       if (cfg_bus.cfg_we) m_phase = 1;
                1:       m_phase = 2;
                default: if (!cfg_bus.cfg_we) m_phase = 0;
            endcase
            m_e[9] = (m_phase == 1);
            m_e[8] = m_b;
            for (int i = 0; i < NCH; i++) begin
                if (m_wr && int'(cfg_bus.cfg_ch) == i) begin
                    m_per[i] = int'(cfg_bus.cfg_period);
                    m_k[i]   = 0;
                end else if (m_b && ch_en[i] && m_per[i] != 0) begin
                    m_k[i]++;
                    if (m_k[i] % m_per[i] == 0) m_e[4+i] = 1'b1;
                end
`ifdef RELOJ_SQW_EN
                if (m_per[i] != 0) m_e[i] = 1'(((m_k[i] / m_per[i]) % 2));
`endif
            end
        end
        exp_q.push_back(m_e);
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected output word per clock; reset overrides to all-zero immediately.
    logic [9:0] mon_e;
    always @(negedge clkin) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (!rstn) mon_e = '0;
            check("cfg_ack",   {3'b0, cfg_bus.cfg_ack}, {3'b0, mon_e[9]});
            check("tick_base", {3'b0, tick_base},       {3'b0, mon_e[8]});
            check("tick",      tick,                    mon_e[7:4]);
            check("clk_div",   clk_div,                 mon_e[3:0]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clkin);
            #2;
        end
    endtask

    task automatic cfg_write(input int ch, input int per, input int hold);
        int t;
        bit seen;
        cfg_bus.cfg_ch     = 2'(ch);
        cfg_bus.cfg_period = 16'(per);
        cfg_bus.cfg_we     = 1'b1;
        seen = 0;
        t    = 0;
        while (!seen && t < 10) begin
            cyc(1);
            t++;
            if (cfg_bus.cfg_ack) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack within 10 cycles at %0t", $time);
        end
        cyc(hold);
        cfg_bus.cfg_we = 1'b0;
        cyc(2);
    endtask

    // Stall until the next edge is a base tick on which channel 0 wraps.
    task automatic wait_wrap0();
        int t;
        bit hit;
        hit = 0;
        t   = 0;
        while (!hit && t < 100) begin
            if (((m_n + 1) % PRE == 0) && ch_en[0] && m_per[0] != 0 &&
                ((m_k[0] + 1) % m_per[0] == 0)) hit = 1;
            else begin
                cyc(1);
                t++;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wrap_wait: got no wrap expected wrap within 100 cycles at %0t", $time);
        end
    endtask

    initial begin
        cfg_bus.cfg_we     = 1'b0;
        cfg_bus.cfg_ch     = 2'd0;
        cfg_bus.cfg_period = 16'd0;
        cyc(3);
        rstn = 1'b1;
        cyc(12);

        ch_en = 4'b0001;
        cfg_write(0, 3, 0);
        cyc(60);

        ch_en = 4'b0011;
        cfg_write(1, 0, 0);
        cyc(200);

        wait_wrap0();
        cfg_write(0, 2, 0);
        cyc(30);

        ch_en = 4'b0111;
        cfg_write(2, 5, 10);
        cyc(40);

        ch_en = 4'b0110;
        cyc(20);
        ch_en = 4'b0111;
        cyc(40);

        cyc(5);
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;
        cyc(10);

        for (int it = 0; it < 60; it++) begin
            ch_en = 4'($urandom);
            cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 3)));
            cyc(int'($urandom_range(0, 40)));
        end

        cyc(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shared timebase controller for the clock-division resources of the FPGA board. A single prescaler derives a base tick from `clkin`. NCH independent channels each divide that tick by a runtime-programmable period and emit one-cycle enable strobes plus an optional square wave. The per-channel periods are written over a simple req/ack configuration port. The block replaces scattered fixed-constant dividers with one configurable scheduler that feeds every slow-rate consumer (display scan, debounce, LED blink).

## Interface
- PRE_CNT, 50000: clkin cycles per base tick (≥2).
- NCH, 4: number of channels (1..4).
- CW, 2: width of channel select.
- PW, 16: width of channel period.
- clkin  in  1  system clock; all logic on its rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- cfg_we  in  1  configuration write request; held high until cfg_ack is seen.
- cfg_ch  in  CW  target channel.
- cfg_period  in  PW  new period, in base ticks; 0 = channel stopped.
- cfg_ack  out  1  one-cycle write acknowledge.
- ch_en  in  NCH  per-channel run enable.
- tick_base  out  1  one-cycle strobe, every PRE_CNT cycles.
- tick  out  NCH  per-channel one-cycle strobe.
- clk_div  out  NCH  per-channel square wave.

## Operation
- Reset (rstn low, asynchronous):
  - Prescaler, channel counters and period registers clear to 0.
  - cfg_ack, tick_base, tick and clk_div are all 0.
  - The config FSM goes to IDLE.
- Prescaler:
  - pre_cnt counts 0..PRE_CNT-1 and wraps.
  - Internal strobe b = (pre_cnt == PRE_CNT-1).
- Channel i is active when ch_en[i]=1 and period[i]≠0.
  - On b with the channel active: if cnt[i]==period[i]-1, then cnt[i]←0, tick[i] pulses and clk_div[i] toggles. Otherwise cnt[i]++.
  - With ch_en[i]=0: cnt[i] and clk_div[i] hold; no tick.
  - With period[i]=0: cnt[i] is held at 0; clk_div[i] holds; no tick.
- Config FSM (states IDLE, ACK, WAIT):
  - IDLE→ACK when cfg_we=1. In that same edge: period[cfg_ch]←cfg_period, cnt[cfg_ch]←0, clk_div[cfg_ch]←0.
  - ACK: cfg_ack=1 for exactly one cycle, then →WAIT.
  - WAIT→IDLE when cfg_we=0. A held cfg_we produces exactly one write and one ack.
  - cfg_ch ≥ NCH: no register changes, but the write is still acknowledged.
- Simultaneous write and wrap on the same channel: the write wins. No tick that cycle; the counter restarts from 0.
- Period arithmetic: channel tick period = PRE_CNT × period clkin cycles. clk_div period is twice that. Counters are PW bits and never exceed period-1.

## Timing
- tick_base and tick[i] are registered from b. They assert in the cycle after pre_cnt == PRE_CNT-1, so tick[i] coincides with a tick_base pulse.
- After rstn deasserts, the first tick_base appears PRE_CNT cycles later.
- After a period write, the first tick on that channel comes period[i] base ticks later.
- cfg_ack: 1 cycle after cfg_we is first sampled high.
- Write-to-effect latency: 0 cycles. The new period governs the next b.
- Reset mid-operation clears everything immediately. No partial tick or ack may appear after rstn falls.

## Configuration
- RELOJ_SQW_EN:
  - Defined: clk_div toggle flops are built, with behaviour as above.
  - Undefined: clk_div is tied to 0 and the toggle logic is omitted. tick and tick_base are unaffected.

## Structure
- Shared package `reloj_pkg` (include file): config FSM state encodings (IDLE=2'd0, ACK=2'd1, WAIT=2'd2) and default widths PW and CW.
- One sub-module, `tick_channel`: holds the period register, counter, tick and square-wave flop for a single channel. It is instantiated NCH times by generate.
- The prescaler and config FSM stay in the top level.

## Test plan
All scenarios use PRE_CNT=4, NCH=4.
- Reset release → all outputs 0; first tick_base on cycle 4 after rstn rises, then every 4 cycles.
- Write ch0 period=3, ch_en=4'b0001 → cfg_ack one cycle after cfg_we; tick[0] every 12 cycles; clk_div[0] period 24 cycles; ticks on other channels stay 0.
- ch1 period=0 with ch_en[1]=1 → tick[1] and clk_div[1] never change over 200 cycles.
- Rewrite ch0 period=2 exactly on a wrap cycle → no tick that cycle; next tick[0] 8 cycles later; clk_div[0] forced 0.
- cfg_we held high for 10 cycles → exactly one cfg_ack pulse; one register update.
- ch_en[0] dropped for 20 cycles, then restored → tick[0] resumes with the count preserved. A later rstn pulse mid-count clears all outputs within the same cycle.
